// File: rtl/cpu_out_checker_if.sv
// rtl/cpu_out_checker_if.sv - bus interface between a run driver and the CPU output checker
// Groups table-load, run-control, monitored CPU output and verdict/diagnostic signals.
// master: drives load/start/abort/dut_out and observes results; slave: the checker.
interface cpu_out_checker_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CYC_W  = 32
);
    localparam int IDX_W = $clog2(DEPTH + 1);

    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] dut_out;
    logic [IDX_W-1:0]  table_count;
    logic              table_full;
    logic              busy;
    logic              done;
    logic              pass;
    logic              fail;
    logic              timeout;
    logic [IDX_W-1:0]  match_count;
    logic [DATA_W-1:0] fail_value;
    logic [CYC_W-1:0]  cycle_count;

    modport master (
        output load_valid, load_data, start, abort, dut_out,
        input  table_count, table_full, busy, done, pass, fail, timeout,
               match_count, fail_value, cycle_count
    );

    modport slave (
        input  load_valid, load_data, start, abort, dut_out,
        output table_count, table_full, busy, done, pass, fail, timeout,
               match_count, fail_value, cycle_count
    );
endinterface

// File: rtl/cpu_out_checker.sv
// rtl/cpu_out_checker.sv - run monitor comparing successive CPU out changes against a loaded table
// Ports: clk (rising edge), reset (sync, active-high), bus (cpu_out_checker_if.slave):
//   load_valid/load_data fill the table in IDLE; start begins a run; abort returns to IDLE;
//   dut_out is the monitored CPU output; table_count/table_full report fill level;
//   busy/done/pass/fail/timeout give run status; match_count/fail_value/cycle_count diagnose it.
module cpu_out_checker #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024,
    parameter int CYC_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    cpu_out_checker_if.slave bus
);
    localparam int IDX_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TMR_W  = $clog2(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] table_q [DEPTH];
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [IDX_W-1:0]  table_count_q, table_count_d;
    logic              table_full_q, table_full_d;
    logic [IDX_W-1:0]  match_count_q, match_count_d;
    logic [CYC_W-1:0]  cycle_count_q, cycle_count_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [DATA_W-1:0] fail_value_q, fail_value_d;
    logic              busy_q, done_q, pass_q, fail_q, timeout_q;
    logic              load_en;
    logic              change;
    logic              hit;

    always_comb begin
        state_d       = state_q;
        prev_d        = prev_q;
        table_count_d = table_count_q;
        match_count_d = match_count_q;
        cycle_count_d = cycle_count_q;
        timer_d       = timer_q;
        fail_value_d  = fail_value_q;
        load_en       = 1'b0;
        change        = (bus.dut_out != prev_q);
        // match_count < table_count <= DEPTH while running, so the slice stays in range
        hit           = (bus.dut_out == table_q[match_count_q[ADDR_W-1:0]]);

        case (state_q)
            S_IDLE, S_PASS, S_FAIL, S_TOUT: begin
                // a load request always shadows start; loading itself is IDLE-only
                if (bus.load_valid) begin
                    if (state_q == S_IDLE && !table_full_q) begin
                        load_en       = 1'b1;
                        table_count_d = table_count_q + IDX_W'(1);
                    end
                end else if (bus.start) begin
                    prev_d        = bus.dut_out;
                    match_count_d = '0;
                    cycle_count_d = '0;
                    timer_d       = '0;
                    fail_value_d  = '0;
                    state_d       = (table_count_q == '0) ? S_PASS : S_RUN;
                end
            end
            S_RUN: begin
                prev_d = bus.dut_out;
                if (cycle_count_q != {CYC_W{1'b1}}) cycle_count_d = cycle_count_q + CYC_W'(1);
                if (change) begin
                    if (hit) begin
                        match_count_d = match_count_q + IDX_W'(1);
                        timer_d       = '0;
                        if ((match_count_q + IDX_W'(1)) == table_count_q) state_d = S_PASS;
                    end else begin
                        fail_value_d = bus.dut_out;
                        state_d      = S_FAIL;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                    if (timer_q == TMR_W'(TIMEOUT - 1)) state_d = S_TOUT;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // abort freezes diagnostics and the table, only the state moves
        if (bus.abort) begin
            state_d       = S_IDLE;
            prev_d        = prev_q;
            table_count_d = table_count_q;
            match_count_d = match_count_q;
            cycle_count_d = cycle_count_q;
            timer_d       = timer_q;
            fail_value_d  = fail_value_q;
            load_en       = 1'b0;
        end

        table_full_d = (table_count_d == IDX_W'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            prev_q        <= '0;
            table_count_q <= '0;
            table_full_q  <= 1'b0;
            match_count_q <= '0;
            cycle_count_q <= '0;
            timer_q       <= '0;
            fail_value_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_q        <= prev_d;
            table_count_q <= table_count_d;
            table_full_q  <= table_full_d;
            match_count_q <= match_count_d;
            cycle_count_q <= cycle_count_d;
            timer_q       <= timer_d;
            fail_value_q  <= fail_value_d;
            busy_q        <= (state_d == S_RUN);
            done_q        <= (state_d == S_PASS) || (state_d == S_FAIL) || (state_d == S_TOUT);
            pass_q        <= (state_d == S_PASS);
            fail_q        <= (state_d == S_FAIL);
            timeout_q     <= (state_d == S_TOUT);
        end
    end

    // table contents are don't-care after reset, so no reset branch here
    always_ff @(posedge clk) begin
        if (load_en) table_q[table_count_q[ADDR_W-1:0]] <= bus.load_data;
    end

    assign bus.table_count = table_count_q;
    assign bus.table_full  = table_full_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.pass        = pass_q;
    assign bus.fail        = fail_q;
    assign bus.timeout     = timeout_q;
    assign bus.match_count = match_count_q;
    assign bus.fail_value  = fail_value_q;
    assign bus.cycle_count = cycle_count_q;
endmodule
